// File: rtl/cl_dram_scrubber.sv
// DRAM scrubber: zero-fills [ADDR_BASE, ADDR_BASE+MEM_SIZE) with full-width AXI write bursts,
// one burst in flight, stoppable and resumable at burst granularity via scrb_enable.
module cl_dram_scrubber #(
    parameter logic [63:0] ADDR_BASE = 64'h0,
    parameter logic [63:0] MEM_SIZE  = 64'h4_0000_0000,
    parameter int unsigned BURST_LEN = 64,
    parameter logic [15:0] AXI_ID    = 16'h0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         scrb_enable,
    output logic [63:0]  scrb_addr,
    output logic [2:0]   scrb_state,
    output logic         scrb_done,
    output logic         scrb_err,
    output logic [15:0]  awid,
    output logic [63:0]  awaddr,
    output logic [7:0]   awlen,
    output logic [2:0]   awsize,
    output logic         awvalid,
    input  logic         awready,
    output logic [15:0]  wid,
    output logic [511:0] wdata,
    output logic [63:0]  wstrb,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,
    input  logic [15:0]  bid,
    input  logic [1:0]   bresp,
    input  logic         bvalid,
    output logic         bready
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AW   = 3'd1,
        ST_W    = 3'd2,
        ST_B    = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [6:0]  LAST_BEAT   = 7'(BURST_LEN - 1);
    localparam logic [7:0]  AWLEN_VAL   = 8'(BURST_LEN - 1);
    localparam logic [63:0] BURST_BYTES = 64'(BURST_LEN) * 64'd64;
    localparam logic [63:0] END_ADDR    = ADDR_BASE + MEM_SIZE;

    state_t        state_r;
    logic [6:0]    beat_r;
    logic [63:0]   addr_r;
    logic [63:0]   awaddr_r;
    logic [15:0]   awid_r;
    logic [7:0]    awlen_r;
    logic [2:0]    awsize_r;
    logic          awvalid_r;
    logic [15:0]   wid_r;
    logic [63:0]   wstrb_r;
    logic          wlast_r;
    logic          wvalid_r;
    logic          bready_r;
    logic          done_r;
    logic          err_r;
    logic [63:0]   next_addr_s;
    logic          unused_s;

    assign next_addr_s = addr_r + BURST_BYTES;
    // Responses are accepted from any ID; only one burst is ever outstanding.
    assign unused_s    = ^bid;

    // Sweep FSM; every AXI output is a register so valids never follow readies combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            beat_r    <= 7'd0;
            addr_r    <= ADDR_BASE;
            awaddr_r  <= 64'd0;
            awid_r    <= 16'd0;
            awlen_r   <= 8'd0;
            awsize_r  <= 3'd0;
            awvalid_r <= 1'b0;
            wid_r     <= 16'd0;
            wstrb_r   <= 64'd0;
            wlast_r   <= 1'b0;
            wvalid_r  <= 1'b0;
            bready_r  <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (scrb_enable) begin
                        state_r   <= ST_AW;
                        err_r     <= 1'b0;
                        awvalid_r <= 1'b1;
                        awaddr_r  <= addr_r;
                        awid_r    <= AXI_ID;
                        awlen_r   <= AWLEN_VAL;
                        awsize_r  <= 3'd6;
                    end
                end
                ST_AW: begin
                    if (awready) begin
                        state_r   <= ST_W;
                        awvalid_r <= 1'b0;
                        beat_r    <= 7'd0;
                        wvalid_r  <= 1'b1;
                        wid_r     <= AXI_ID;
                        wstrb_r   <= {64{1'b1}};
                        wlast_r   <= (LAST_BEAT == 7'd0);
                    end
                end
                ST_W: begin
                    if (wready) begin
                        if (beat_r == LAST_BEAT) begin
                            state_r  <= ST_B;
                            wvalid_r <= 1'b0;
                            wlast_r  <= 1'b0;
                            bready_r <= 1'b1;
                        end else begin
                            beat_r  <= beat_r + 7'd1;
                            wlast_r <= ((beat_r + 7'd1) == LAST_BEAT);
                        end
                    end
                end
                ST_B: begin
                    if (bvalid) begin
                        bready_r <= 1'b0;
                        err_r    <= err_r | (bresp != 2'b00);
                        addr_r   <= next_addr_s;
                        // Enable is only sampled here, so a stop never truncates a burst.
                        if (next_addr_s == END_ADDR) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else if (scrb_enable) begin
                            state_r   <= ST_AW;
                            awvalid_r <= 1'b1;
                            awaddr_r  <= next_addr_s;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
                ST_DONE: begin
                    if (!scrb_enable) begin
                        state_r <= ST_IDLE;
                        done_r  <= 1'b0;
                        addr_r  <= ADDR_BASE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    awvalid_r <= 1'b0;
                    wvalid_r  <= 1'b0;
                    wlast_r   <= 1'b0;
                    bready_r  <= 1'b0;
                end
            endcase
        end
    end

    assign scrb_addr  = addr_r;
    assign scrb_state = state_r;
    assign scrb_done  = done_r;
    assign scrb_err   = err_r;
    assign awid       = awid_r;
    assign awaddr     = awaddr_r;
    assign awlen      = awlen_r;
    assign awsize     = awsize_r;
    assign awvalid    = awvalid_r;
    assign wid        = wid_r;
    assign wdata      = 512'd0;
    assign wstrb      = wstrb_r;
    assign wlast      = wlast_r;
    assign wvalid     = wvalid_r;
    assign bready     = bready_r;

endmodule

// File: tb/tb_cl_dram_scrubber.sv
// Directed bench for cl_dram_scrubber: expected burst addresses are queued when a sweep is
// started and popped on each AW handshake; a cycle model checks W/B ordering and stability.
module tb_cl_dram_scrubber;

    logic         clk;
    logic         rst_n;
    logic         scrb_enable;
    logic [63:0]  scrb_addr;
    logic [2:0]   scrb_state;
    logic         scrb_done;
    logic         scrb_err;
    logic [15:0]  awid;
    logic [63:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic         awvalid;
    logic         awready;
    logic [15:0]  wid;
    logic [511:0] wdata;
    logic [63:0]  wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic [15:0]  bid;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;

    cl_dram_scrubber #(
        .ADDR_BASE (64'h0),
        .MEM_SIZE  (64'h4000),
        .BURST_LEN (64),
        .AXI_ID    (16'h0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .scrb_enable (scrb_enable),
        .scrb_addr   (scrb_addr),
        .scrb_state  (scrb_state),
        .scrb_done   (scrb_done),
        .scrb_err    (scrb_err),
        .awid        (awid),
        .awaddr      (awaddr),
        .awlen       (awlen),
        .awsize      (awsize),
        .awvalid     (awvalid),
        .awready     (awready),
        .wid         (wid),
        .wdata       (wdata),
        .wstrb       (wstrb),
        .wlast       (wlast),
        .wvalid      (wvalid),
        .wready      (wready),
        .bid         (bid),
        .bresp       (bresp),
        .bvalid      (bvalid),
        .bready      (bready)
    );

    always #5 clk = ~clk;

    int          checks;
    int          errors;
    logic [63:0] exp_q[$];
    bit          rand_mode;
    bit          aw_open;
    bit          b_pend;
    bit          aw_stall;
    bit          w_stall;
    logic [63:0] aw_hold;
    int          beats;
    int          b_count;
    int          aw_total;
    int          err_burst;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"}, scrb_addr, 64'h0);
        check({tag, "_state"}, 64'(scrb_state), 64'd0);
        check({tag, "_aw"}, 64'(|{awid, awaddr, awlen, awsize, awvalid}), 64'd0);
        check({tag, "_w"}, 64'(|{wid, wdata, wstrb, wlast, wvalid}), 64'd0);
        check({tag, "_ctl"}, 64'(|{bready, scrb_done, scrb_err}), 64'd0);
    endtask

    // One clock: drive responder inputs, check current outputs against the model, advance.
    task automatic step();
        logic [63:0] want;
        if (rand_mode) begin
            awready = ($urandom_range(0, 3) != 0);
            wready  = ($urandom_range(0, 3) != 0);
            bvalid  = b_pend && ($urandom_range(0, 2) == 0);
        end else begin
            awready = 1'b1;
            wready  = 1'b1;
            bvalid  = b_pend;
        end
        bresp = (b_count == err_burst) ? 2'b10 : 2'b00;
        if (rst_n) begin
            check("state_legal", 64'(scrb_state <= 3'd4), 64'd1);
            if (aw_stall) begin
                check("aw_held", 64'(awvalid), 64'd1);
                check("aw_stable", awaddr, aw_hold);
            end
            if (awvalid) begin
                if (awready) begin
                    check("aw_single", 64'(aw_open || b_pend), 64'd0);
                    want = 64'hDEAD_BEEF_DEAD_BEEF;
                    if (exp_q.size() > 0) want = exp_q.pop_front();
                    check("awaddr", awaddr, want);
                    check("aw_fields", {37'd0, awid, awlen, awsize}, {37'd0, 16'h0, 8'd63, 3'd6});
                    aw_open  = 1'b1;
                    beats    = 0;
                    aw_stall = 1'b0;
                    aw_total++;
                end else begin
                    aw_stall = 1'b1;
                    aw_hold  = awaddr;
                end
            end else begin
                aw_stall = 1'b0;
            end
            if (w_stall) check("w_held", 64'(wvalid), 64'd1);
            if (wvalid) begin
                check("w_after_aw", 64'(aw_open), 64'd1);
                check("wlast", 64'(wlast), 64'(beats == 63));
                if (wready) begin
                    check("w_payload", 64'({wid == 16'h0, wdata == 512'd0, wstrb == {64{1'b1}}}), 64'd7);
                    beats++;
                    w_stall = 1'b0;
                    if (wlast) begin
                        check("beat_count", 64'(beats), 64'd64);
                        aw_open = 1'b0;
                        b_pend  = 1'b1;
                    end
                end else begin
                    w_stall = 1'b1;
                end
            end else begin
                w_stall = 1'b0;
            end
            if (bready && bvalid) begin
                check("b_pending", 64'(b_pend), 64'd1);
                b_pend = 1'b0;
                b_count++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_state(input logic [2:0] target, input string tag);
        for (int i = 0; i < 4000 && scrb_state != target; i++) step();
        check(tag, 64'(scrb_state), 64'(target));
    endtask

    task automatic push_sweep(input logic [63:0] first, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(first + 64'(i) * 64'h1000);
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; scrb_enable = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = 16'h0; bresp = 2'b00;
        checks = 0; errors = 0; rand_mode = 1'b0; aw_open = 1'b0; b_pend = 1'b0;
        aw_stall = 1'b0; w_stall = 1'b0; aw_hold = 64'd0; beats = 0; b_count = 0;
        aw_total = 0; err_burst = -1;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Full sweep, no stalls
        push_sweep(64'h0, 4);
        b_count = 0;
        scrb_enable = 1'b1;
        wait_state(3'd4, "sweep_done_state");
        check("sweep_done", 64'(scrb_done), 64'd1);
        check("sweep_end_addr", scrb_addr, 64'h4000);
        check("sweep_err", 64'(scrb_err), 64'd0);
        check("sweep_bursts", 64'(b_count), 64'd4);
        check("sweep_queue", 64'(exp_q.size()), 64'd0);

        // Hold enable in DONE, then restart
        for (int i = 0; i < 5; i++) begin
            step();
            check("done_held", 64'(scrb_done), 64'd1);
        end
        scrb_enable = 1'b0;
        step();
        check("restart_done", 64'(scrb_done), 64'd0);
        check("restart_addr", scrb_addr, 64'h0);
        check("restart_state", 64'(scrb_state), 64'd0);

        // Sweep from 0 again under random backpressure
        rand_mode = 1'b1;
        push_sweep(64'h0, 4);
        b_count = 0;
        scrb_enable = 1'b1;
        wait_state(3'd4, "bp_done_state");
        check("bp_end_addr", scrb_addr, 64'h4000);
        check("bp_bursts", 64'(b_count), 64'd4);
        check("bp_queue", 64'(exp_q.size()), 64'd0);
        scrb_enable = 1'b0;
        step();
        rand_mode = 1'b0;

        // Stop during W of burst 2, then resume
        push_sweep(64'h0, 2);
        b_count = 0;
        aw_total = 0;
        scrb_enable = 1'b1;
        for (int i = 0; i < 4000 && !(aw_total == 2 && scrb_state == 3'd2); i++) step();
        check("stop_in_w", 64'(scrb_state), 64'd2);
        scrb_enable = 1'b0;
        wait_state(3'd0, "stop_idle");
        check("stop_addr", scrb_addr, 64'h2000);
        check("stop_bursts", 64'(b_count), 64'd2);
        check("stop_queue", 64'(exp_q.size()), 64'd0);
        push_sweep(64'h2000, 2);
        scrb_enable = 1'b1;
        step();
        check("idle_to_aw", 64'(scrb_state), 64'd1);
        wait_state(3'd4, "resume_done_state");
        check("resume_end_addr", scrb_addr, 64'h4000);
        check("resume_queue", 64'(exp_q.size()), 64'd0);
        scrb_enable = 1'b0;
        step();

        // Error response on the first burst
        push_sweep(64'h0, 4);
        b_count = 0;
        err_burst = 0;
        scrb_enable = 1'b1;
        wait_state(3'd4, "err_done_state");
        check("err_at_done", 64'(scrb_err), 64'd1);
        scrb_enable = 1'b0;
        step();
        check("err_idle_state", 64'(scrb_state), 64'd0);
        check("err_sticky_idle", 64'(scrb_err), 64'd1);
        err_burst = -1;
        push_sweep(64'h0, 4);
        b_count = 0;
        scrb_enable = 1'b1;
        step();
        check("err_clear_state", 64'(scrb_state), 64'd1);
        check("err_cleared", 64'(scrb_err), 64'd0);
        wait_state(3'd4, "clean_done_state");
        check("clean_err", 64'(scrb_err), 64'd0);
        scrb_enable = 1'b0;
        step();

        // Asynchronous reset in the middle of W
        push_sweep(64'h0, 1);
        b_count = 0;
        scrb_enable = 1'b1;
        for (int i = 0; i < 4000 && !(scrb_state == 3'd2 && beats >= 5); i++) step();
        check("mid_w_reached", 64'(scrb_state), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        exp_q.delete();
        aw_open = 1'b0; b_pend = 1'b0; aw_stall = 1'b0; w_stall = 1'b0;
        scrb_enable = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("post_rst_valids", 64'({awvalid, wvalid, bready}), 64'd0);
            check("post_rst_state", 64'(scrb_state), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
